inta_sequencer: RTL

INTA_SEQUENCER -- requirements
Module: inta_sequencer

---
 rtl/inta_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/inta_sequencer.sv
// -----------------------------------------------------------------------------
// inta_sequencer
//
// 8259-style interrupt acknowledge sequencer. Raises INT toward the CPU when
// the priority resolver requests service, then walks the two-pulse INTA
// handshake:
//   * first INTA fall  : latch the granted level, set its ISR bit and pulse
//                        the matching IRR clear (or flag a spurious interrupt
//                        on level 7 if the request has already gone away)
//   * second INTA fall : drive {vector_base, level} onto the data bus
//   * second INTA rise : release the bus and the resolver freeze
// The block owns the in-service register and applies specific and
// non-specific EOI commands to it in any state.
//
// Build option:
//   PIC_AEOI_EN - automatic EOI. The serviced ISR bit is cleared on the
//                 closing INTA rise. This does not apply to spurious
//                 interrupts. When the macro is undefined, ISR bits clear
//                 only through eoi_strobe.
// -----------------------------------------------------------------------------
module inta_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       int_req,
  input  logic [2:0] resolved_index,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       eoi_strobe,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic       freeze,
  output logic [7:0] irr_clr,
  output logic [7:0] isr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ACK1  = 3'd2,
    S_WAIT2 = 3'd3,
    S_ACK2  = 3'd4
  } state_e;

  state_e     state_q;
  logic       inta_q;
  logic [2:0] level_q;
  logic       spurious_q;
  logic       int_out_q;
  logic       freeze_q;
  logic [7:0] irr_clr_q;
  logic [7:0] isr_q;
  logic [7:0] data_out_q;
  logic       data_oe_q;

  logic       inta_fall;
  logic       inta_rise;
  logic [7:0] isr_set;
  logic [7:0] aeoi_clr;
  logic [7:0] eoi_clr;
  logic [7:0] isr_d;

  // Edge detect on the (already synchronous) acknowledge strobe.
  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  // ISR next state: the set from a fresh acknowledge overrides any clear aimed
  // at the same bit, so the level being serviced cannot be lost to an EOI.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    isr_set  = '0;
    aeoi_clr = '0;
    eoi_clr  = '0;

    if (state_q == S_REQ && inta_fall && int_req) begin
      isr_set = 8'b1 << resolved_index;
    end

`ifdef PIC_AEOI_EN
    if (state_q == S_ACK2 && inta_rise && !spurious_q) begin
      aeoi_clr = 8'b1 << level_q;
    end
`else
    aeoi_clr = '0;
`endif

    if (eoi_strobe) begin
      if (eoi_specific) begin
        eoi_clr = 8'b1 << eoi_level;
      end else begin
        // Two's-complement trick: isolates the lowest set bit. It yields
        // zero when the ISR is empty, so a non-specific EOI is then a no-op.
        eoi_clr = isr_q & (~isr_q + 8'd1);
      end
    end

    isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | isr_set;
  end

  // Acknowledge FSM with all outputs registered. Also holds the ISR and the
  // INTA edge-detect flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      inta_q     <= 1'b1;
      level_q    <= 3'd0;
      spurious_q <= 1'b0;
      int_out_q  <= 1'b0;
      freeze_q   <= 1'b0;
      irr_clr_q  <= '0;
      isr_q      <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // right-hand side therefore sees the pre-edge values, whatever the
      // statement order.
      inta_q    <= inta_n;
      isr_q     <= isr_d;
      irr_clr_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (int_req) begin
            state_q   <= S_REQ;
            int_out_q <= 1'b1;
          end
        end

        S_REQ: begin
          if (inta_fall) begin
            state_q   <= S_ACK1;
            freeze_q  <= 1'b1;
            int_out_q <= 1'b0;
            if (int_req) begin
              level_q    <= resolved_index;
              spurious_q <= 1'b0;
              irr_clr_q  <= isr_set;
            end else begin
              // The request vanished before the acknowledge. Answer with
              // level 7 and leave both the ISR and the IRR untouched.
              level_q    <= 3'd7;
              spurious_q <= 1'b1;
            end
          end
        end

        S_ACK1: begin
          if (inta_rise) begin
            state_q <= S_WAIT2;
          end
        end

        S_WAIT2: begin
          if (inta_fall) begin
            state_q    <= S_ACK2;
            data_oe_q  <= 1'b1;
            data_out_q <= {vector_base, level_q};
          end
        end

        S_ACK2: begin
          if (inta_rise) begin
            state_q    <= S_IDLE;
            data_oe_q  <= 1'b0;
            data_out_q <= '0;
            freeze_q   <= 1'b0;
            spurious_q <= 1'b0;
          end else begin
            data_out_q <= {vector_base, level_q};
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign int_out  = int_out_q;
  assign freeze   = freeze_q;
  assign irr_clr  = irr_clr_q;
  assign isr      = isr_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

endmodule
